// File: rtl/q1_pkg.sv
// Shared encodings for the q1 instruction sequencer: opcodes, FSM states and the
// datapath select codes driven towards the register/ALU block.
package q1_pkg;

  localparam int unsigned OpWidth = 3;

  typedef enum logic [OpWidth-1:0] {
    OpNop  = 3'b000,
    OpLdi  = 3'b001,
    OpMov  = 3'b010,
    OpXor  = 3'b011,
    OpAnd  = 3'b100,
    OpShl  = 3'b101,
    OpIll6 = 3'b110,
    OpIll7 = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StLatch,
    StWrite,
    StDone
  } state_e;

  // Register-write source
  localparam logic [1:0] SrIn  = 2'b00;
  localparam logic [1:0] SrAlu = 2'b01;
  localparam logic [1:0] SrTmp = 2'b10;

  localparam logic [1:0] AluXor   = 2'b00;
  localparam logic [1:0] AluAnd   = 2'b01;
  localparam logic [1:0] AluShl   = 2'b10;
  localparam logic [1:0] AluPassB = 2'b11;

  localparam logic [2:0] TselAlu = 3'b000;
  localparam logic [2:0] TselR0  = 3'b001;
  localparam logic [2:0] TselB   = 3'b010;

  localparam logic [2:0] BselR1 = 3'b000;
  localparam logic [2:0] BselR2 = 3'b001;
  localparam logic [2:0] BselR3 = 3'b010;

  // B bus only reaches R1..R3, so the source index is shifted down by one.
  function automatic logic [2:0] rs_to_bsel(input logic [1:0] rs);
    return {1'b0, rs - 2'd1};
  endfunction

endpackage

// File: rtl/q1_ctrl_if.sv
// Instruction handshake plus datapath control bundle between the q1 sequencer,
// its instruction source and the register/ALU datapath.
interface q1_ctrl_if;

  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr;
  logic [7:0] imm;

  logic [7:0] in;
  logic [1:0] sr;
  logic [1:0] Rn;
  logic       w;
  logic [1:0] aluop;
  logic       lt;
  logic [2:0] tsel;
  logic [2:0] bsel;

  logic       busy;
  logic       done;
  logic       err;

  // Instruction source / datapath side
  modport master (
    output instr_valid, instr, imm,
    input  instr_ready, in, sr, Rn, w, aluop, lt, tsel, bsel, busy, done, err
  );

  // Sequencer side
  modport slave (
    input  instr_valid, instr, imm,
    output instr_ready, in, sr, Rn, w, aluop, lt, tsel, bsel, busy, done, err
  );

endinterface

// File: rtl/q1_ctrl_decode.sv
// Combinational opcode decode: legality plus the static select codes an
// instruction needs across its SETUP/LATCH/WRITE sequence.
module q1_ctrl_decode
  import q1_pkg::*;
(
  input  op_e        op,
  input  logic [1:0] rs,
  output logic       legal,
  output logic       needs_latch,
  output logic [2:0] tsel,
  output logic [2:0] bsel,
  output logic [1:0] sr,
  output logic [1:0] aluop
);

  always_comb begin
    legal       = 1'b0;
    needs_latch = 1'b0;
    tsel        = TselAlu;
    bsel        = BselR1;
    sr          = SrIn;
    aluop       = AluXor;

    unique case (op)
      OpNop: begin
        legal = 1'b1;
      end
      OpLdi: begin
        legal = 1'b1;
        sr    = SrIn;
      end
      // R0 cannot be a B source, so rs == 0 is illegal for the B-sourced ops.
      OpMov: begin
        legal       = (rs != 2'd0);
        needs_latch = 1'b1;
        tsel        = TselB;
        bsel        = rs_to_bsel(rs);
        sr          = SrTmp;
      end
      OpXor: begin
        legal       = (rs != 2'd0);
        needs_latch = 1'b1;
        tsel        = TselR0;
        bsel        = rs_to_bsel(rs);
        sr          = SrAlu;
        aluop       = AluXor;
      end
      OpAnd: begin
        legal       = (rs != 2'd0);
        needs_latch = 1'b1;
        tsel        = TselR0;
        bsel        = rs_to_bsel(rs);
        sr          = SrAlu;
        aluop       = AluAnd;
      end
      OpShl: begin
        legal       = 1'b1;
        needs_latch = 1'b1;
        tsel        = TselR0;
        bsel        = BselR1;
        sr          = SrAlu;
        aluop       = AluShl;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/q1_ctrl.sv
// q1 instruction sequencer: accepts one instruction over valid/ready and plays out
// the registered datapath control sequence, finishing with a done (and err) pulse.
module q1_ctrl
  import q1_pkg::*;
#(
  parameter int unsigned OPW = OpWidth
) (
  input logic     clk,
  input logic     reset,
  q1_ctrl_if.slave bus
);

  state_e     state_q, state_d;
  op_e        op_q;
  logic [1:0] rd_q, rs_q;
  logic [7:0] imm_q;

  logic       accept;
  op_e        op_sel;
  logic [1:0] rd_sel, rs_sel;
  logic [7:0] imm_sel;

  logic       dec_legal, dec_needs_latch;
  logic [2:0] dec_tsel, dec_bsel;
  logic [1:0] dec_sr, dec_aluop;

  logic [7:0] in_q, in_d;
  logic [1:0] sr_q, sr_d;
  logic [1:0] rn_q, rn_d;
  logic       w_q, w_d;
  logic [1:0] aluop_q, aluop_d;
  logic       lt_q, lt_d;
  logic [2:0] tsel_q, tsel_d;
  logic [2:0] bsel_q, bsel_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       ready_q, ready_d;

  logic       unused_instr_lsb;
  assign unused_instr_lsb = bus.instr[0];

  assign accept = bus.instr_valid & ready_q;

  // On the accept cycle decode straight from the bus so the first registered
  // outputs are already correct; afterwards use the captured fields.
  assign op_sel  = accept ? op_e'(bus.instr[7 -: OPW]) : op_q;
  assign rd_sel  = accept ? bus.instr[4:3] : rd_q;
  assign rs_sel  = accept ? bus.instr[2:1] : rs_q;
  assign imm_sel = accept ? bus.imm : imm_q;

  q1_ctrl_decode u_decode (
    .op          (op_sel),
    .rs          (rs_sel),
    .legal       (dec_legal),
    .needs_latch (dec_needs_latch),
    .tsel        (dec_tsel),
    .bsel        (dec_bsel),
    .sr          (dec_sr),
    .aluop       (dec_aluop)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!dec_legal) begin
            state_d = StDone;
          end else if (dec_needs_latch) begin
            state_d = StSetup;
          end else if (op_sel == OpLdi) begin
            state_d = StWrite;
          end else begin
            state_d = StDone;
          end
        end
      end
      StSetup: state_d = StLatch;
      StLatch: state_d = StWrite;
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are a function of the state being entered so they can be registered.
  always_comb begin
    in_d    = 8'h00;
    sr_d    = SrIn;
    rn_d    = 2'd0;
    w_d     = 1'b0;
    aluop_d = AluXor;
    lt_d    = 1'b0;
    tsel_d  = TselAlu;
    bsel_d  = BselR1;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ready_d = (state_d == StIdle);
    busy_d  = (state_d != StIdle);

    unique case (state_d)
      StSetup: begin
        tsel_d = dec_tsel;
        bsel_d = dec_bsel;
      end
      StLatch: begin
        tsel_d = dec_tsel;
        bsel_d = dec_bsel;
        lt_d   = 1'b1;
      end
      StWrite: begin
        tsel_d  = dec_tsel;
        bsel_d  = dec_bsel;
        sr_d    = dec_sr;
        aluop_d = dec_aluop;
        rn_d    = rd_sel;
        w_d     = 1'b1;
        if (op_sel == OpLdi) begin
          in_d = imm_sel;
        end
      end
      StDone: begin
        done_d = 1'b1;
        err_d  = ~dec_legal;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= OpNop;
      rd_q    <= 2'd0;
      rs_q    <= 2'd0;
      imm_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= op_sel;
        rd_q  <= rd_sel;
        rs_q  <= rs_sel;
        imm_q <= imm_sel;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_q    <= 8'h00;
      sr_q    <= SrIn;
      rn_q    <= 2'd0;
      w_q     <= 1'b0;
      aluop_q <= AluXor;
      lt_q    <= 1'b0;
      tsel_q  <= TselAlu;
      bsel_q  <= BselR1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      in_q    <= in_d;
      sr_q    <= sr_d;
      rn_q    <= rn_d;
      w_q     <= w_d;
      aluop_q <= aluop_d;
      lt_q    <= lt_d;
      tsel_q  <= tsel_d;
      bsel_q  <= bsel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.in          = in_q;
  assign bus.sr          = sr_q;
  assign bus.Rn          = rn_q;
  assign bus.w           = w_q;
  assign bus.aluop       = aluop_q;
  assign bus.lt          = lt_q;
  assign bus.tsel        = tsel_q;
  assign bus.bsel        = bsel_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_q1_ctrl.sv
// Bench for q1_ctrl: directed instruction stream, a behavioural q1 datapath driven by
// the control lines, and a scoreboard of expected completions and register contents.
module tb_q1_ctrl;
  import q1_pkg::*;

  logic clk = 1'b0;
  logic reset;

  q1_ctrl_if bus ();

  q1_ctrl #(.OPW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       err;
    int         lat;
    int         wn;
    int         ltn;
    logic [1:0] sr;
    logic [1:0] rn;
    logic [7:0] in;
    logic [1:0] aluop;
    logic       chk_alu;
    logic [2:0] tsel;
    logic [2:0] bsel;
    logic [31:0] rf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int last_done_cyc = -10;
  int w_cnt = 0;
  int lt_cnt = 0;
  bit ovl = 1'b0;

  logic [7:0] exp_rf [4];
  logic [7:0] saved_rf [4];
  logic [7:0] rf [4];
  logic [7:0] tmp;
  logic [7:0] b_val;
  logic [7:0] alu_val;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural q1 register/ALU datapath
  always_comb begin
    b_val = 8'h00;
    case (bus.bsel)
      3'b000:  b_val = rf[1];
      3'b001:  b_val = rf[2];
      3'b010:  b_val = rf[3];
      default: b_val = 8'h00;
    endcase
    alu_val = 8'h00;
    case (bus.aluop)
      2'b00:   alu_val = tmp ^ b_val;
      2'b01:   alu_val = tmp & b_val;
      2'b10:   alu_val = {tmp[6:0], 1'b0};
      default: alu_val = b_val;
    endcase
  end

  always @(posedge bus.lt) begin
    case (bus.tsel)
      3'b001:  tmp <= rf[0];
      3'b010:  tmp <= b_val;
      default: tmp <= alu_val;
    endcase
  end

  always @(posedge clk) begin
    if (bus.w) begin
      case (bus.sr)
        2'b00:   rf[bus.Rn] <= bus.in;
        2'b01:   rf[bus.Rn] <= alu_val;
        2'b10:   rf[bus.Rn] <= tmp;
        default: rf[bus.Rn] <= 8'hxx;
      endcase
    end
  end

  // Monitor: pulse accounting per instruction and scoreboard pop on done
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.instr_valid && bus.instr_ready) begin
        acc_cyc = cyc;
        w_cnt   = 0;
        lt_cnt  = 0;
        ovl     = 1'b0;
      end
      if (bus.w && bus.lt) ovl = 1'b1;
      if (bus.err && !bus.done) ovl = 1'b1;
      if (bus.w) begin
        w_cnt++;
        if (sb.size() > 0) begin
          check("w_ctl", {bus.sr, bus.Rn, bus.in, bus.tsel, bus.bsel},
                {sb[0].sr, sb[0].rn, sb[0].in, sb[0].tsel, sb[0].bsel});
          if (sb[0].chk_alu) check("w_aluop", bus.aluop, sb[0].aluop);
        end
      end
      if (bus.lt) begin
        lt_cnt++;
        if (sb.size() > 0) check("lt_sel", {bus.tsel, bus.bsel}, {sb[0].tsel, sb[0].bsel});
      end
      if (bus.done) begin
        check("done_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check("err", bus.err, mon_e.err);
          check("latency", cyc - acc_cyc, mon_e.lat);
          check("w_lt_pulses", {w_cnt, lt_cnt}, {mon_e.wn, mon_e.ltn});
          check("w_lt_overlap", ovl, 0);
          check("regfile", {rf[3], rf[2], rf[1], rf[0]}, mon_e.rf);
        end
        last_done_cyc = cyc;
      end
    end
  end

  // Call at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic [7:0] imm, input bit hold, input bit b2b);
    exp_t e;
    bit got;
    bit legal;
    logic [7:0] res;
    logic [31:0] junk;
    e = '{default: '0};
    res = 8'h00;
    legal = (op <= 3'd5) && !((op inside {3'd2, 3'd3, 3'd4}) && rs == 2'd0);
    e.lat = 1;
    e.err = ~legal;
    e.chk_alu = 1'b1;
    e.bsel = (rs == 2'd1) ? 3'b000 : (rs == 2'd2) ? 3'b001 : 3'b010;
    if (legal) begin
      case (op)
        3'd1: begin e.lat = 2; e.wn = 1; e.in = imm; e.bsel = 3'b000; res = imm; end
        3'd2: begin
          e.lat = 4; e.wn = 1; e.ltn = 1; e.sr = 2'b10; e.tsel = 3'b010; e.chk_alu = 1'b0;
          res = exp_rf[rs];
        end
        3'd3: begin
          e.lat = 4; e.wn = 1; e.ltn = 1; e.sr = 2'b01; e.tsel = 3'b001; e.aluop = 2'b00;
          res = exp_rf[0] ^ exp_rf[rs];
        end
        3'd4: begin
          e.lat = 4; e.wn = 1; e.ltn = 1; e.sr = 2'b01; e.tsel = 3'b001; e.aluop = 2'b01;
          res = exp_rf[0] & exp_rf[rs];
        end
        3'd5: begin
          e.lat = 4; e.wn = 1; e.ltn = 1; e.sr = 2'b01; e.tsel = 3'b001; e.aluop = 2'b10;
          e.bsel = 3'b000; res = {exp_rf[0][6:0], 1'b0};
        end
        default: e.bsel = 3'b000;
      endcase
    end else begin
      e.bsel = 3'b000;
    end
    if (e.wn == 0) e.bsel = 3'b000;
    e.rn = (e.wn == 1) ? rd : 2'd0;

    junk = $urandom;
    bus.instr_valid = 1'b1;
    bus.instr = {op, rd, rs, junk[0]};
    bus.imm = imm;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.instr_ready) got = 1'b1;
    end
    check("accept", got, 1);
    if (got) begin
      if (e.wn == 1) exp_rf[rd] = res;
      e.rf = {exp_rf[3], exp_rf[2], exp_rf[1], exp_rf[0]};
      sb.push_back(e);
      if (b2b) check("b2b_accept_cycle", cyc, last_done_cyc + 1);
    end
    @(posedge clk);
    #1;
    // Scramble the bus after accept; the captured copy must be what executes.
    junk = $urandom;
    bus.instr_valid = hold;
    bus.instr = junk[7:0];
    bus.imm = junk[15:8];
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr = 8'h00;
    bus.imm = 8'h00;
    step(2);
    check("reset_outputs",
          {bus.in, bus.sr, bus.Rn, bus.w, bus.aluop, bus.lt, bus.tsel, bus.bsel,
           bus.busy, bus.done, bus.err, bus.instr_ready}, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("ready_before_edge", bus.instr_ready, 0);
    @(posedge clk);
    #1;
    check("ready_after_reset", bus.instr_ready, 1);

    issue(3'd1, 2'd2, 2'd0, 8'hA5, 0, 0);  // LDI R2=A5
    issue(3'd1, 2'd0, 2'd0, 8'h3C, 0, 0);  // LDI R0=3C
    issue(3'd1, 2'd1, 2'd0, 8'h0F, 0, 0);  // LDI R1=0F
    issue(3'd3, 2'd3, 2'd1, 8'h00, 0, 0);  // XOR R3=R0^R1=33
    issue(3'd1, 2'd0, 2'd0, 8'h81, 0, 0);  // LDI R0=81
    issue(3'd5, 2'd1, 2'd2, 8'h00, 0, 0);  // SHL R1=02
    issue(3'd2, 2'd0, 2'd0, 8'h00, 0, 0);  // MOV rs=0: illegal
    issue(3'd7, 2'd1, 2'd1, 8'hFF, 0, 0);  // illegal op
    issue(3'd6, 2'd2, 2'd3, 8'h11, 0, 0);  // illegal op
    issue(3'd0, 2'd3, 2'd2, 8'h22, 0, 0);  // NOP
    issue(3'd2, 2'd2, 2'd3, 8'h00, 0, 0);  // MOV R2=R3
    issue(3'd4, 2'd0, 2'd1, 8'h00, 1, 0);  // AND R0=R0&R1, valid held afterwards
    step(2);
    issue(3'd1, 2'd3, 2'd0, 8'h5A, 0, 1);  // LDI R3=5A, back-to-back
    issue(3'd1, 2'd1, 2'd0, 8'hC3, 0, 0);
    issue(3'd3, 2'd2, 2'd1, 8'h00, 0, 0);  // XOR R2=R0^R1

    // Reset during the LATCH cycle of a MOV
    saved_rf = exp_rf;
    issue(3'd2, 2'd1, 2'd3, 8'h00, 0, 0);
    for (int i = 0; i < 8 && !bus.lt; i++) @(negedge clk);
    check("lt_before_reset", bus.lt, 1);
    #2;
    reset = 1'b1;
    #1;
    check("reset_async",
          {bus.w, bus.lt, bus.busy, bus.done, bus.err, bus.instr_ready}, 0);
    sb.delete();
    exp_rf = saved_rf;
    step(2);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("ready_low_after_release", bus.instr_ready, 0);
    @(posedge clk);
    #1;
    check("ready_back", bus.instr_ready, 1);

    issue(3'd1, 2'd0, 2'd0, 8'hA9, 0, 0);  // LDI R0=A9
    issue(3'd5, 2'd3, 2'd0, 8'h00, 0, 0);  // SHL R3=52

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/q1_ctrl.md
Name: q1_ctrl

Overview:
Instruction sequencer sitting directly upstream of the q1 register/ALU datapath. It accepts one instruction at a time over a valid/ready handshake and decodes it. It then drives the datapath control lines (in, sr, Rn, w, aluop, lt, tsel, bsel) as a timed multi-cycle sequence, and reports completion with done/err pulses.

Parameters:
OPW, 3, opcode field width; fixed encoding below, not intended for override.

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state and outputs immediately
instr_valid  input  1  instruction offered
instr_ready  output  1  controller can accept; high only in IDLE
instr  input  8  [7:5]=op, [4:3]=rd, [2:1]=rs, [0] ignored
imm  input  8  immediate for LDI, sampled at accept
in  output  8  datapath immediate bus
sr  output  2  register-write source select (00 in, 01 alu_out, 10 tmp)
Rn  output  2  destination register index
w  output  1  register write strobe
aluop  output  2  00 XOR, 01 AND, 10 SHL(tmp), 11 pass B
lt  output  1  tmp latch strobe; datapath captures on its rising edge
tsel  output  3  tmp source (000 alu_out, 001 R0, 010 B)
bsel  output  3  B source (000 R1, 001 R2, 010 R3)
busy  output  1  state != IDLE
done  output  1  one-cycle completion pulse
err  output  1  one-cycle pulse coincident with done for illegal instructions

Behaviour:
- All control outputs registered. Default values: in=0, sr=00, Rn=00, w=0, aluop=00, lt=0, tsel=000, bsel=000, done=0, err=0. The same defaults apply during reset.
- Opcodes: 000 NOP, 001 LDI, 010 MOV, 011 XOR, 100 AND, 101 SHL, 110/111 illegal.
- Accept occurs when instr_valid && instr_ready. op, rd, rs and imm are captured at accept; later changes on instr/imm have no effect.
- States: IDLE, SETUP, LATCH, WRITE, DONE.
- LDI: IDLE→WRITE→DONE→IDLE.
  - WRITE drives in=imm, sr=00, Rn=rd, w=1.
  - done is asserted 2 cycles after accept.
- MOV/XOR/AND/SHL: IDLE→SETUP→LATCH→WRITE→DONE→IDLE. done is asserted 4 cycles after accept.
  - SETUP: tsel and bsel driven; lt=0.
  - LATCH: lt=1 for exactly one cycle; tsel/bsel held.
  - WRITE: lt=0; Rn=rd, w=1 for exactly one cycle; tsel/bsel still held.
  - MOV: tsel=010, bsel=rs-1; WRITE sr=10 (Rd ← Rs).
  - XOR: tsel=001, bsel=rs-1; WRITE sr=01, aluop=00 (Rd ← R0 ^ Rs).
  - AND: as XOR but aluop=01 (Rd ← R0 & Rs).
  - SHL: tsel=001, bsel=000; WRITE sr=01, aluop=10 (Rd ← R0<<1, bit 7 dropped, LSB 0). rs is ignored.
- NOP: IDLE→DONE; done=1, err=0; no w/lt activity.
- Illegal cases: op 110/111, or rs=00 on MOV/XOR/AND (R0 is not a B source).
  - Sequence: IDLE→DONE with done=1, err=1.
  - w and lt are never asserted.
- w and lt are never high in the same cycle. Outside WRITE, w=0; outside LATCH, lt=0.
- instr_ready=0 in every non-IDLE state. An offered instruction waits, and the source holds it.
- Back-to-back: the next accept is possible in the cycle after DONE (minimum spacing is 3 cycles for LDI, 5 cycles for ALU ops).
- Reset mid-operation: outputs return to defaults asynchronously (w and lt drop immediately). The in-flight instruction is discarded with no done. State returns to IDLE; instr_ready rises on the first clock edge after reset deasserts.

Decomposition:
- Package q1_pkg: opcode enum; state enum; constants for the sr, aluop, tsel and bsel encodings.
- One sub-module, q1_ctrl_decode (combinational):
  - inputs: op, rs
  - outputs: legal, needs_latch, tsel, bsel, sr, aluop
- q1_ctrl holds the FSM and the output registers.

Test Plan:
- Reset, then LDI rd=2 imm=8'hA5 → WRITE cycle has Rn=10, sr=00, in=A5, w=1. done is asserted 2 cycles after accept; R2 reads A5.
- LDI R0=8'h3C, LDI R1=8'h0F, XOR rd=3 rs=1:
  - lt pulses one cycle with tsel=001.
  - WRITE has bsel=000, aluop=00, sr=01, w=1.
  - R3 = 8'h33; done is asserted 4 cycles after accept.
- LDI R0=8'h81, SHL rd=1 → R1 = 8'h02; lt and w each high for exactly one cycle, never together.
- MOV rd=0 rs=0 and op=111 → done and err pulse together 1 cycle after accept; w and lt stay 0; register contents unchanged.
- Hold instr_valid high during an AND sequence → instr_ready stays 0 until IDLE. The second instruction is accepted the cycle after done, and its captured fields match the values present at that accept.
- Assert reset during the LATCH cycle of MOV → lt and w go 0 without waiting for clk. No done pulse; instr_ready returns after reset deasserts.
